// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   In-order tracker for in-flight conditional branches. Fetch pushes each
//   predicted branch and execute resolves them oldest-first. Each resolution
//   trains the two-bit predictor through update_*. A wrong prediction raises a
//   one-cycle mispredict with the redirect PC and flushes the queue.
//
// Parameters
//   DEPTH    in-flight entries (power of two, >= 2)
//   PARK_PC  predictor address driven on idle cycles (reserved index)
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   alloc_valid/ready            fetch push handshake
//   alloc_pc/pred/alt_pc         branch PC, predicted direction, alternate PC
//   resolve_valid/taken          execute resolves the oldest entry
//   update_pc/outcome/valid      registered predictor training port
//   mispredict, redirect_pc      registered one-cycle redirect pulse + target
//   resolve_error                sticky: resolve seen with an empty queue
//   count                        occupied entries
//
// Optional build macro
//   BRU_STATS_EN  adds saturating counters stat_branches / stat_mispredicts
module branch_resolve_unit #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PARK_PC = 32'h0000_00FC
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [31:0]              alloc_pc,
  input  logic                     alloc_pred,
  input  logic [31:0]              alloc_alt_pc,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic [31:0]              update_pc,
  output logic                     update_outcome,
  output logic                     update_valid,
  output logic                     mispredict,
  output logic [31:0]              redirect_pc,
  output logic                     resolve_error,
  output logic [$clog2(DEPTH):0]   count
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]              stat_branches,
  output logic [15:0]              stat_mispredicts
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [31:0]   alt_q  [DEPTH];
  logic [31:0]   alt_d  [DEPTH];
  logic          pred_q [DEPTH];
  logic          pred_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   update_pc_q, update_pc_d;
  logic          update_outcome_q, update_outcome_d;
  logic          update_valid_q, update_valid_d;
  logic          mispredict_q, mispredict_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic          resolve_error_q, resolve_error_d;

  logic          do_alloc;
  logic          do_resolve;
  logic          do_flush;

  // Gated on registered count only, so a full queue refuses alloc even while
  // the same cycle pops an entry.
  assign alloc_ready = (count_q < CW'(DEPTH));
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_resolve  = resolve_valid && (count_q != '0);
  assign do_flush    = do_resolve && (resolve_taken != pred_q[head_q]);

  always_comb begin
    pc_d             = pc_q;
    alt_d            = alt_q;
    pred_d           = pred_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    update_valid_d   = 1'b0;
    update_pc_d      = PARK_PC;
    update_outcome_d = 1'b0;
    mispredict_d     = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    resolve_error_d  = resolve_error_q | (resolve_valid && (count_q == '0));

    if (do_alloc) begin
      pc_d[tail_q]   = alloc_pc;
      alt_d[tail_q]  = alloc_alt_pc;
      pred_d[tail_q] = alloc_pred;
      tail_d         = tail_q + PW'(1);
    end

    if (do_resolve) begin
      head_d           = head_q + PW'(1);
      update_valid_d   = 1'b1;
      update_pc_d      = pc_q[head_q];
      update_outcome_d = resolve_taken;
    end

    count_d = count_q + CW'(do_alloc) - CW'(do_resolve);

    // Flush overrides any same-cycle allocation; the stale write into the
    // array is harmless because the pointers restart at zero.
    if (do_flush) begin
      mispredict_d  = 1'b1;
      redirect_pc_d = alt_q[head_q];
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        alt_q[i]  <= '0;
        pred_q[i] <= 1'b0;
      end
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      update_pc_q      <= PARK_PC;
      update_outcome_q <= 1'b0;
      update_valid_q   <= 1'b0;
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      resolve_error_q  <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      alt_q            <= alt_d;
      pred_q           <= pred_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      update_pc_q      <= update_pc_d;
      update_outcome_q <= update_outcome_d;
      update_valid_q   <= update_valid_d;
      mispredict_q     <= mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      resolve_error_q  <= resolve_error_d;
    end
  end

  assign update_pc      = update_pc_q;
  assign update_outcome = update_outcome_q;
  assign update_valid   = update_valid_q;
  assign mispredict     = mispredict_q;
  assign redirect_pc    = redirect_pc_q;
  assign resolve_error  = resolve_error_q;
  assign count          = count_q;

`ifdef BRU_STATS_EN
  logic [15:0] stat_branches_q, stat_branches_d;
  logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (do_resolve && (stat_branches_q != 16'hFFFF))
      stat_branches_d = stat_branches_q + 16'd1;
    if (do_flush && (stat_mispredicts_q != 16'hFFFF))
      stat_mispredicts_d = stat_mispredicts_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clock;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [31:0] alloc_pc;
  logic        alloc_pred;
  logic [31:0] alloc_alt_pc;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] update_pc;
  logic        update_outcome;
  logic        update_valid;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        resolve_error;
  logic [2:0]  count;
`ifdef BRU_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int checks = 0;
  int fails  = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_resolve_unit #(.DEPTH(4), .PARK_PC(32'h0000_00FC)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_pred(alloc_pred), .alloc_alt_pc(alloc_alt_pc),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .update_pc(update_pc), .update_outcome(update_outcome),
    .update_valid(update_valid), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .resolve_error(resolve_error), .count(count)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid   = 1'b0;
    alloc_pc      = '0;
    alloc_pred    = 1'b0;
    alloc_alt_pc  = '0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic pred, input logic [31:0] alt);
    alloc_valid  = 1'b1;
    alloc_pc     = pc;
    alloc_pred   = pred;
    alloc_alt_pc = alt;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
    checks++; if (redirect_pc !== 32'h0) begin fails++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
    checks++; if (resolve_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", resolve_error); end
    checks++; if (update_outcome !== 1'b0) begin fails++; $display("FAIL reset_outcome: got %b want 0", update_outcome); end
`ifdef BRU_STATS_EN
    checks++; if (stat_branches !== 16'd0) begin fails++; $display("FAIL reset_stat_br: got %0d want 0", stat_branches); end
    checks++; if (stat_mispredicts !== 16'd0) begin fails++; $display("FAIL reset_stat_mp: got %0d want 0", stat_mispredicts); end
`endif
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (update_pc !== 32'hFC) begin fails++; $display("FAIL idle_update_pc[%0d]: got %h want 000000fc", i, update_pc); end
      checks++; if (update_valid !== 1'b0) begin fails++; $display("FAIL idle_update_valid[%0d]: got %b want 0", i, update_valid); end
      checks++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL idle_ready[%0d]: got %b want 1", i, alloc_ready); end
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL idle_count[%0d]: got %0d want 0", i, count); end
      checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL idle_mispredict[%0d]: got %b want 0", i, mispredict); end
    end
  endtask

  task automatic test_basic();
    set_alloc(32'h100, 1'b1, 32'h104);
    cycle();
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL basic_count_after_alloc: got %0d want 1", count); end
    alloc_valid   = 1'b0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    cycle();
    exp_br++;
    checks++; if (update_valid !== 1'b1) begin fails++; $display("FAIL basic_update_valid: got %b want 1", update_valid); end
    checks++; if (update_pc !== 32'h100) begin fails++; $display("FAIL basic_update_pc: got %h want 00000100", update_pc); end
    checks++; if (update_outcome !== 1'b1) begin fails++; $display("FAIL basic_outcome: got %b want 1", update_outcome); end
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL basic_mispredict: got %b want 0", mispredict); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL basic_count: got %0d want 0", count); end
    idle_inputs();
    cycle();
    checks++; if (update_valid !== 1'b0) begin fails++; $display("FAIL basic_idle_valid: got %b want 0", update_valid); end
    checks++; if (update_pc !== 32'hFC) begin fails++; $display("FAIL basic_idle_pc: got %h want 000000fc", update_pc); end
    checks++; if (update_outcome !== 1'b0) begin fails++; $display("FAIL basic_idle_outcome: got %b want 0", update_outcome); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_alloc(32'h300 + 32'(4 * i), 1'b0, 32'h340 + 32'(4 * i));
      cycle();
    end
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", alloc_ready); end
    set_alloc(32'h310, 1'b0, 32'h350);
    cycle();
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL full_fifth_ignored: got %0d want 4", count); end
    set_alloc(32'h320, 1'b1, 32'h360);
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    cycle();
    exp_br++;
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL full_pop_refuse_count: got %0d want 3", count); end
    checks++; if (update_pc !== 32'h300) begin fails++; $display("FAIL full_pop_pc: got %h want 00000300", update_pc); end
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL full_pop_mispredict: got %b want 0", mispredict); end
    checks++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL full_pop_ready: got %b want 1", alloc_ready); end
    alloc_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cycle();
      exp_br++;
      checks++; if (update_pc !== 32'h300 + 32'(4 * i)) begin fails++; $display("FAIL full_drain_pc[%0d]: got %h want %h", i, update_pc, 32'h300 + 32'(4 * i)); end
      checks++; if (update_outcome !== 1'b0) begin fails++; $display("FAIL full_drain_outcome[%0d]: got %b want 0", i, update_outcome); end
    end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL full_drained_count: got %0d want 0", count); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_back_to_back();
    set_alloc(32'h400, 1'b1, 32'h800);
    cycle();
    resolve_taken = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_alloc(32'h400 + 32'(16 * i), 1'b1, 32'h800);
      resolve_valid = 1'b1;
      cycle();
      exp_br++;
      checks++; if (update_pc !== 32'h400 + 32'(16 * (i - 1))) begin fails++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, update_pc, 32'h400 + 32'(16 * (i - 1))); end
      checks++; if (count !== 3'd1) begin fails++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, count); end
      checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL b2b_mispredict[%0d]: got %b want 0", i, mispredict); end
    end
    alloc_valid = 1'b0;
    cycle();
    exp_br++;
    checks++; if (update_pc !== 32'h450) begin fails++; $display("FAIL b2b_last_pc: got %h want 00000450", update_pc); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_last_count: got %0d want 0", count); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_mispredict();
    set_alloc(32'h200, 1'b0, 32'h240); cycle();
    set_alloc(32'h210, 1'b0, 32'h250); cycle();
    set_alloc(32'h220, 1'b0, 32'h260); cycle();
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL mp_count_before: got %0d want 3", count); end
    set_alloc(32'h230, 1'b1, 32'h234);
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    cycle();
    exp_br++; exp_mp++;
    checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL mp_pulse: got %b want 1", mispredict); end
    checks++; if (redirect_pc !== 32'h240) begin fails++; $display("FAIL mp_redirect: got %h want 00000240", redirect_pc); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL mp_flush_count: got %0d want 0", count); end
    checks++; if (update_pc !== 32'h200) begin fails++; $display("FAIL mp_update_pc: got %h want 00000200", update_pc); end
    checks++; if (update_outcome !== 1'b1) begin fails++; $display("FAIL mp_outcome: got %b want 1", update_outcome); end
    idle_inputs();
    cycle();
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL mp_one_cycle: got %b want 0", mispredict); end
    checks++; if (redirect_pc !== 32'h240) begin fails++; $display("FAIL mp_redirect_hold: got %h want 00000240", redirect_pc); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL mp_alloc_discarded: got %0d want 0", count); end
    set_alloc(32'h260, 1'b1, 32'h264);
    cycle();
    alloc_valid   = 1'b0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    cycle();
    exp_br++; exp_mp++;
    checks++; if (update_pc !== 32'h260) begin fails++; $display("FAIL mp2_update_pc: got %h want 00000260", update_pc); end
    checks++; if (update_outcome !== 1'b0) begin fails++; $display("FAIL mp2_outcome: got %b want 0", update_outcome); end
    checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL mp2_pulse: got %b want 1", mispredict); end
    checks++; if (redirect_pc !== 32'h264) begin fails++; $display("FAIL mp2_redirect: got %h want 00000264", redirect_pc); end
    idle_inputs();
    cycle();
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL mp2_one_cycle: got %b want 0", mispredict); end
    checks++; if (redirect_pc !== 32'h264) begin fails++; $display("FAIL mp2_redirect_hold: got %h want 00000264", redirect_pc); end
  endtask

  task automatic test_error();
    checks++; if (resolve_error !== 1'b0) begin fails++; $display("FAIL err_before: got %b want 0", resolve_error); end
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    cycle();
    checks++; if (resolve_error !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", resolve_error); end
    checks++; if (update_valid !== 1'b0) begin fails++; $display("FAIL err_no_update: got %b want 0", update_valid); end
    checks++; if (update_pc !== 32'hFC) begin fails++; $display("FAIL err_park_pc: got %h want 000000fc", update_pc); end
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL err_no_mispredict: got %b want 0", mispredict); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL err_count: got %0d want 0", count); end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (resolve_error !== 1'b1) begin fails++; $display("FAIL err_sticky[%0d]: got %b want 1", i, resolve_error); end
    end
`ifdef BRU_STATS_EN
    checks++; if (stat_branches !== 16'(exp_br)) begin fails++; $display("FAIL stat_branches: got %0d want %0d", stat_branches, exp_br); end
    checks++; if (stat_mispredicts !== 16'(exp_mp)) begin fails++; $display("FAIL stat_mispredicts: got %0d want %0d", stat_mispredicts, exp_mp); end
`endif
  endtask

  task automatic test_reset_mid();
    set_alloc(32'h500, 1'b0, 32'h540); cycle();
    set_alloc(32'h510, 1'b0, 32'h550); cycle();
    set_alloc(32'h520, 1'b0, 32'h560); cycle();
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL rst_mid_count_before: got %0d want 3", count); end
    alloc_valid   = 1'b0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL rst_mid_async_count: got %0d want 0", count); end
    checks++; if (resolve_error !== 1'b0) begin fails++; $display("FAIL rst_mid_error: got %b want 0", resolve_error); end
    checks++; if (redirect_pc !== 32'h0) begin fails++; $display("FAIL rst_mid_redirect: got %h want 0", redirect_pc); end
    cycle();
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (update_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_update[%0d]: got %b want 0", i, update_valid); end
      checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL rst_mid_mispredict[%0d]: got %b want 0", i, mispredict); end
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL rst_mid_count[%0d]: got %0d want 0", i, count); end
      checks++; if (update_pc !== 32'hFC) begin fails++; $display("FAIL rst_mid_pc[%0d]: got %h want 000000fc", i, update_pc); end
    end
`ifdef BRU_STATS_EN
    checks++; if (stat_branches !== 16'd0) begin fails++; $display("FAIL rst_mid_stat_br: got %0d want 0", stat_branches); end
    checks++; if (stat_mispredicts !== 16'd0) begin fails++; $display("FAIL rst_mid_stat_mp: got %0d want 0", stat_mispredicts); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_mispredict();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
